// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2^N one-hot decoder with enable and auto-scan.
//
// Drives exactly one select line (or none) at a time. Typical use is
// digit or row select for multiplexed display and keypad drivers.
//
// Parameters:
//   N       - select width; the output is 2^N lines wide
//   DWELL_W - width of the dwell counter and of the dwell input
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   en    - enable; when low the block is OFF and all lines are 0
//   mode  - 0 = direct decode of in, 1 = auto-scan
//   in    - direct-mode select; in scan mode, the target index for load
//   load  - in scan mode, jumps the scan index to in and restarts the dwell
//   dwell - extra cycles each index is held in scan mode (0 = every cycle)
//   out   - registered one-hot (or all-zero) select lines
//   idx   - registered current index
//   wrap  - one-cycle pulse when a scan advance takes idx from 2^N-1 to 0

module dec_scan #(
  parameter int N       = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       in,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    out,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int W = 2**N;

  localparam logic [N-1:0]       IDX_ZERO = {N{1'b0}};
  localparam logic [N-1:0]       IDX_ONE  = N'(1'b1);
  localparam logic [N-1:0]       IDX_MAX  = {N{1'b1}};
  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1'b1);
  localparam logic [W-1:0]       OUT_ZERO = {W{1'b0}};

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             state_r;
  logic [N-1:0]       idx_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [W-1:0]       out_r;
  logic               wrap_r;
  logic [N-1:0]       idx_inc_s;

  // One-hot decode of an index; the only way a select pattern is formed,
  // so out can never carry more than one high bit.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    logic [W-1:0] v;
    v      = OUT_ZERO;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Next scan index; N-bit arithmetic wraps 2^N-1 back to 0 naturally.
  assign idx_inc_s = idx_r + IDX_ONE;

  // Mode FSM: state, index, dwell counter and registered outputs.
  // The sampled en/mode pick the new state directly, so every state change
  // shows up on out one cycle after it is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_OFF;
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      out_r   <= OUT_ZERO;
      wrap_r  <= 1'b0;
    end else begin
      // wrap is a pulse: only the advance branch below can raise it
      wrap_r <= 1'b0;
      if (!en) begin
        // OFF keeps idx so a later scan resumes where it stopped
        state_r <= ST_OFF;
        cnt_r   <= CNT_ZERO;
        out_r   <= OUT_ZERO;
      end else if (!mode) begin
        state_r <= ST_DIRECT;
        idx_r   <= in;
        cnt_r   <= CNT_ZERO;
        out_r   <= onehot(in);
      end else begin
        state_r <= ST_SCAN;
        case (state_r)
          ST_SCAN: begin
            if (load) begin
              // load wins over a coincident dwell expiry and never wraps
              idx_r <= in;
              cnt_r <= CNT_ZERO;
              out_r <= onehot(in);
            end else if (cnt_r == dwell) begin
              idx_r  <= idx_inc_s;
              cnt_r  <= CNT_ZERO;
              out_r  <= onehot(idx_inc_s);
              wrap_r <= (idx_r == IDX_MAX);
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
              out_r <= onehot(idx_r);
            end
          end
          default: begin
            // Entering scan from OFF or DIRECT: show the retained index and
            // start a full dwell; load is only honoured once already scanning.
            cnt_r <= CNT_ZERO;
            out_r <= onehot(idx_r);
          end
        endcase
      end
    end
  end

  assign out  = out_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_dec_scan.sv
// Testbench for dec_scan: directed scenarios on an N=2 instance, plus a
// randomised en/mode/load run on an N=3, DWELL_W=4 instance with a small
// reference model. Expected results are queued when stimulus is driven and
// compared once the corresponding clock edge has produced the output.

module tb_dec_scan;

  typedef struct packed {
    logic [3:0] out;
    logic [1:0] idx;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] in;
  logic       load;
  logic [7:0] dwell;
  logic [3:0] out;
  logic [1:0] idx;
  logic       wrap;

  logic       rst3;
  logic       en3;
  logic       mode3;
  logic [2:0] in3;
  logic       load3;
  logic [3:0] dwell3;
  logic [7:0] out3;
  logic [2:0] idx3;
  logic       wrap3;

  int checks;
  int failures;

  exp_t        exp_q[$];
  logic [11:0] exp3_q[$];

  dec_scan #(.N(2), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in), .load(load),
    .dwell(dwell), .out(out), .idx(idx), .wrap(wrap)
  );

  dec_scan #(.N(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .mode(mode3), .in(in3), .load(load3),
    .dwell(dwell3), .out(out3), .idx(idx3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int i, input logic on, input logic w);
    exp_t e;
    logic [3:0] one;
    one   = 4'b0001;
    e.out = on ? (one << i) : 4'b0000;
    e.idx = 2'(i);
    e.wrap = w;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; en = 1'b0; mode = 1'b0; in = 2'd0; load = 1'b0; dwell = 8'd0;
    rst3 = 1'b1; en3 = 1'b0; mode3 = 1'b0; in3 = 3'd0; load3 = 1'b0; dwell3 = 4'd0;
    @(posedge clk); #1;
    e = mk(0, 1'b0, 1'b0);
    checks++;
    if ({out, idx, wrap} !== e) begin
      failures++;
      $display("FAIL reset: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
               out, idx, wrap, e.out, e.idx, e.wrap);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    exp_t e;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in = 2'(i);
        exp_q.push_back(mk(i, 1'b1, 1'b0));
      end else begin
        en = 1'b0;
        exp_q.push_back(mk(3, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL direct_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 i, out, idx, wrap, e.out, e.idx, e.wrap);
      end
    end
  endtask

  // Puts the N=2 instance in DIRECT at index 0 with the given dwell.
  task automatic prep_direct0(input logic [7:0] d);
    exp_t e;
    en = 1'b1; mode = 1'b0; in = 2'd0; load = 1'b0; dwell = d;
    exp_q.push_back(mk(0, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({out, idx, wrap} !== e) begin
      failures++;
      $display("FAIL prep_direct: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
               out, idx, wrap, e.out, e.idx, e.wrap);
    end
  endtask

  task automatic test_scan_dwell0();
    exp_t e;
    prep_direct0(8'd0);
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(mk(k % 4, 1'b1, k == 4));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL scan_d0_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 k, out, idx, wrap, e.out, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_scan_dwell2();
    exp_t e;
    int   wraps;
    wraps = 0;
    prep_direct0(8'd2);
    mode = 1'b1;
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(mk((k / 3) % 4, 1'b1, k == 12));
      @(posedge clk); #1;
      if (wrap === 1'b1) wraps++;
      e = exp_q.pop_front();
      checks++;
      if ({out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL scan_d2_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 k, out, idx, wrap, e.out, e.idx, e.wrap);
      end
    end
    checks++;
    if (wraps !== 1) begin
      failures++;
      $display("FAIL scan_d2_wrap_count: got %0d, expected 1", wraps);
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [9:0] ld_v;
    int         in_v[10];
    int         idx_v[10];
    ld_v  = 10'b0100000100;   // load on steps 2 and 8
    in_v  = '{0, 0, 2, 0, 0, 0, 0, 0, 1, 0};
    idx_v = '{0, 0, 2, 2, 2, 3, 3, 3, 1, 1};
    prep_direct0(8'd2);
    mode = 1'b1;
    for (int s = 0; s < 10; s++) begin
      load = ld_v[s];
      in   = 2'(in_v[s]);
      exp_q.push_back(mk(idx_v[s], 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL load_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 s, out, idx, wrap, e.out, e.idx, e.wrap);
      end
    end
    load = 1'b0;
  endtask

  // Starts in scan at idx=1 (left there by test_load).
  task automatic test_enable_gap();
    exp_t e;
    for (int s = 0; s < 9; s++) begin
      en = (s >= 5);
      if (s < 5) exp_q.push_back(mk(1, 1'b0, 1'b0));
      else       exp_q.push_back(mk(s < 8 ? 1 : 2, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL enable_gap_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 s, out, idx, wrap, e.out, e.idx, e.wrap);
      end
    end
  endtask

  // Starts in scan at idx=2 (left there by test_enable_gap).
  task automatic test_async_reset();
    exp_t e;
    #2;
    rst = 1'b1;
    #1;
    e = mk(0, 1'b0, 1'b0);
    checks++;
    if ({out, idx, wrap} !== e) begin
      failures++;
      $display("FAIL async_reset: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
               out, idx, wrap, e.out, e.idx, e.wrap);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b1; mode = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(k, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({out, idx, wrap} !== e) begin
        failures++;
        $display("FAIL post_reset_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 k, out, idx, wrap, e.out, e.idx, e.wrap);
      end
    end
  endtask

  task automatic test_random_n3();
    logic [11:0] e;
    logic [7:0]  one;
    logic [7:0]  m_out;
    int          m_state;   // 0 OFF, 1 DIRECT, 2 SCAN
    int          m_idx;
    int          m_cnt;
    logic        m_wrap;
    one = 8'b00000001;
    m_state = 0; m_idx = 0; m_cnt = 0;
    dwell3 = 4'd2;
    rst3 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en3   = ($urandom_range(0, 9) != 0);
      mode3 = ($urandom_range(0, 9) > 2);
      load3 = ($urandom_range(0, 7) == 0);
      in3   = 3'($urandom_range(0, 7));
      m_wrap = 1'b0;
      if (!en3) begin
        m_state = 0; m_cnt = 0;
      end else if (!mode3) begin
        m_state = 1; m_idx = in3; m_cnt = 0;
      end else if (m_state != 2) begin
        m_state = 2; m_cnt = 0;
      end else if (load3) begin
        m_idx = in3; m_cnt = 0;
      end else if (m_cnt == dwell3) begin
        m_wrap = (m_idx == 7);
        m_idx  = (m_idx + 1) % 8;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
      m_out = (m_state == 0) ? 8'd0 : (one << m_idx);
      exp3_q.push_back({m_out, 3'(m_idx), m_wrap});
      @(posedge clk); #1;
      e = exp3_q.pop_front();
      checks++;
      if ({out3, idx3, wrap3} !== e || $countones(out3) > 1) begin
        failures++;
        $display("FAIL random_n3_%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 c, out3, idx3, wrap3, e[11:4], e[3:1], e[0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_direct();
    test_scan_dwell0();
    test_scan_dwell2();
    test_load();
    test_enable_gap();
    test_async_reset();
    test_random_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
